// File: rtl/rf_seq_engine.sv
// Micro-sequencer that walks an instruction ROM and issues SPI register accesses,
// interrupt waits and jumps, collecting read results in a small valid/ready FIFO.
module rf_seq_engine #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RD_DEPTH = 4,
  parameter int unsigned TO_W     = 20
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  output logic [PC_W-1:0] o_instr_addr,
  input  logic [23:0]     i_instr_data,
  output logic            o_spi_req,
  output logic [1:0]      o_spi_mode,
  output logic [9:0]      o_spi_addr,
  output logic [7:0]      o_spi_wdata,
  input  logic            i_spi_ready,
  input  logic            i_spi_done,
  input  logic [7:0]      i_spi_rdata,
  input  logic            i_intr,
  output logic            o_intr_ack,
  output logic [7:0]      o_rd_data,
  output logic            o_rd_valid,
  input  logic            i_rd_ready,
  output logic            o_busy,
  output logic            o_halted,
  output logic            o_timeout
);

  localparam int unsigned AW = $clog2(RD_DEPTH);
  localparam logic [AW:0] DepthCnt = (AW+1)'(RD_DEPTH);

  localparam logic [2:0] OpNop      = 3'b000;
  localparam logic [2:0] OpWrShort  = 3'b001;
  localparam logic [2:0] OpWrLong   = 3'b010;
  localparam logic [2:0] OpRdShort  = 3'b011;
  localparam logic [2:0] OpRdLong   = 3'b100;
  localparam logic [2:0] OpWaitIntr = 3'b101;
  localparam logic [2:0] OpJmp      = 3'b110;
  localparam logic [2:0] OpHalt     = 3'b111;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StIssue, StWaitSpi, StWaitInt, StHalt
  } state_e;

  state_e          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_is_rd;
  logic            r_spi_req;
  logic [1:0]      r_spi_mode;
  logic [9:0]      r_spi_addr;
  logic [7:0]      r_spi_wdata;
  logic            r_intr_ack;
  logic            r_timeout;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_mem [RD_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  logic [2:0]      w_op;
  logic [9:0]      w_addr;
  logic            w_short;
  logic            w_write;
  logic            w_can_issue;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_pc_inc;
  logic [TO_W-1:0] w_cnt_inc;
  logic            w_unused;

  assign w_op      = i_instr_data[23:21];
  assign w_addr    = i_instr_data[17:8];
  assign w_unused  = ^i_instr_data[20:18];
  assign w_short   = (w_op == OpWrShort) || (w_op == OpRdShort);
  assign w_write   = (w_op == OpWrShort) || (w_op == OpWrLong);
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_cnt_inc = r_to_cnt + TO_W'(1);

  // Only one SPI op is ever outstanding, so the count seen in ISSUE already
  // reflects every earlier read and the FIFO cannot overflow.
  assign w_can_issue = i_spi_ready && (!r_is_rd || (r_count < DepthCnt));
  assign w_push      = (r_state == StWaitSpi) && i_spi_done && r_is_rd;
  assign w_pop       = (r_count != '0) && i_rd_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_pc        <= '0;
      r_is_rd     <= 1'b0;
      r_spi_req   <= 1'b0;
      r_spi_mode  <= 2'b00;
      r_spi_addr  <= '0;
      r_spi_wdata <= '0;
      r_intr_ack  <= 1'b0;
      r_timeout   <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_spi_req  <= 1'b0;
      r_intr_ack <= 1'b0;
      unique case (r_state)
        StIdle, StHalt: begin
          if (i_start) begin
            r_pc      <= '0;
            r_timeout <= 1'b0;
            r_state   <= StFetch;
          end
        end
        StFetch: r_state <= StDecode;
        StDecode: begin
          unique case (w_op)
            OpNop: begin
              r_pc    <= w_pc_inc;
              r_state <= StFetch;
            end
            OpJmp: begin
              r_pc    <= i_instr_data[PC_W-1:0];
              r_state <= StFetch;
            end
            OpHalt: r_state <= StHalt;
            OpWaitIntr: begin
              r_to_cnt <= '0;
              r_state  <= StWaitInt;
            end
            default: begin
              r_is_rd     <= !w_write;
              r_spi_mode  <= {!w_short, w_write};
              r_spi_addr  <= w_short ? {4'b0000, w_addr[5:0]} : w_addr;
              r_spi_wdata <= i_instr_data[7:0];
              r_state     <= StIssue;
            end
          endcase
        end
        StIssue: begin
          if (w_can_issue) begin
            r_spi_req <= 1'b1;
            r_state   <= StWaitSpi;
          end
        end
        StWaitSpi: begin
          if (i_spi_done) begin
            r_pc    <= w_pc_inc;
            r_state <= StFetch;
          end
        end
        StWaitInt: begin
          if (i_intr) begin
            r_intr_ack <= 1'b1;
            r_pc       <= w_pc_inc;
            r_state    <= StFetch;
          end else if (w_cnt_inc == '1) begin
            r_timeout <= 1'b1;
            r_pc      <= w_pc_inc;
            r_state   <= StFetch;
          end else begin
            r_to_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_spi_rdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop) r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  assign o_instr_addr = r_pc;
  assign o_spi_req    = r_spi_req;
  assign o_spi_mode   = r_spi_mode;
  assign o_spi_addr   = r_spi_addr;
  assign o_spi_wdata  = r_spi_wdata;
  assign o_intr_ack   = r_intr_ack;
  assign o_timeout    = r_timeout;
  assign o_rd_valid   = (r_count != '0);
  assign o_rd_data    = r_mem[r_rptr];
  assign o_busy       = (r_state != StIdle) && (r_state != StHalt);
  assign o_halted     = (r_state == StHalt);

endmodule

// File: tb/tb_rf_seq_engine.sv
// Directed and randomized bench for rf_seq_engine: ROM and SPI slave models plus an
// instruction-level interpreter that predicts the SPI traffic and read-FIFO contents.
module tb_rf_seq_engine;

  localparam int TO_W = 4;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  instr_addr;
  logic [23:0] instr_data = '0;
  logic        spi_req, spi_ready, spi_done, intr, intr_ack;
  logic [1:0]  spi_mode;
  logic [9:0]  spi_addr;
  logic [7:0]  spi_wdata, spi_rdata, rd_data;
  logic        rd_valid, rd_ready, busy, halted, timeout;

  int checks = 0;
  int errors = 0;
  int lat_override = 0;

  logic [23:0] rom [256];
  logic [1:0]  q_mode [$];
  logic [9:0]  q_addr [$];
  logic [7:0]  q_wdata [$];
  logic [7:0]  exp_fifo [$];
  logic [1:0]  e_mode [$];
  logic [9:0]  e_addr [$];
  logic [7:0]  e_wdata [$];

  rf_seq_engine #(.PC_W(8), .RD_DEPTH(4), .TO_W(TO_W)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_instr_addr(instr_addr),
    .i_instr_data(instr_data), .o_spi_req(spi_req), .o_spi_mode(spi_mode),
    .o_spi_addr(spi_addr), .o_spi_wdata(spi_wdata), .i_spi_ready(spi_ready),
    .i_spi_done(spi_done), .i_spi_rdata(spi_rdata), .i_intr(intr), .o_intr_ack(intr_ack),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_busy(busy),
    .o_halted(halted), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word appears the cycle after its address.
  always @(posedge clk) instr_data <= rom[instr_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // SPI slave: random latency, random read data; a reset during the latency kills the push.
  initial begin
    logic [1:0] m;
    logic [9:0] a;
    logic [7:0] w;
    int         lat;
    bit         killed;
    spi_done  = 1'b0;
    spi_rdata = '0;
    forever begin
      tick;
      if (spi_req === 1'b1) begin
        m = spi_mode; a = spi_addr; w = spi_wdata;
        q_mode.push_back(m); q_addr.push_back(a); q_wdata.push_back(w);
        killed = 1'b0;
        lat = (lat_override != 0) ? lat_override : int'($urandom_range(1, 3));
        for (int i = 0; i < lat; i++) begin
          tick;
          if (rst_n !== 1'b1) killed = 1'b1;
          if (i == 0 && !killed) check("req_pulse", 32'(spi_req), 0);
        end
        spi_rdata = 8'($urandom);
        if (!killed) begin
          check("spi_hold", {20'(spi_mode), spi_addr}, {20'(m), a});
          check("spi_hold_wdata", 32'(spi_wdata), 32'(w));
          if (m[0] == 1'b0) exp_fifo.push_back(spi_rdata);
        end
        spi_done = 1'b1;
        tick;
        spi_done = 1'b0;
      end
    end
  end

  function automatic logic [23:0] enc(input logic [2:0] op, input logic [9:0] a,
                                      input logic [7:0] d);
    return {op, 3'($urandom), a, d};
  endfunction

  task automatic fill_rom_halt;
    for (int i = 0; i < 256; i++) rom[i] = {3'b111, 21'd0};
    q_mode.delete(); q_addr.delete(); q_wdata.delete();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int bound);
    int n = 0;
    while (halted !== 1'b1 && n < bound) begin tick; n++; end
    check(tag, 32'(halted), 1);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    check({tag, "_model_nonempty"}, 32'(exp_fifo.size() > 0), 1);
    e = (exp_fifo.size() > 0) ? exp_fifo.pop_front() : 8'h00;
    check({tag, "_valid"}, 32'(rd_valid), 1);
    check({tag, "_data"}, 32'(rd_data), 32'(e));
    rd_ready = 1'b1;
    tick;
    rd_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_halted"}, 32'(halted), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_req"}, 32'(spi_req), 0);
    check({tag, "_mode"}, 32'(spi_mode), 0);
    check({tag, "_addr"}, 32'(spi_addr), 0);
    check({tag, "_wdata"}, 32'(spi_wdata), 0);
    check({tag, "_ack"}, 32'(intr_ack), 0);
    check({tag, "_pc"}, 32'(instr_addr), 0);
  endtask

  // Instruction-level interpreter producing the expected SPI transaction list.
  task automatic interpret(output int halt_pc, output int nreads);
    int pc = 0;
    logic [23:0] wd;
    e_mode.delete(); e_addr.delete(); e_wdata.delete();
    nreads = 0;
    for (int step = 0; step < 64; step++) begin
      wd = rom[pc];
      case (wd[23:21])
        3'd0: pc = (pc + 1) % 256;
        3'd6: pc = int'(wd[7:0]);
        3'd7: break;
        default: begin
          case (wd[23:21])
            3'd1: e_mode.push_back(2'b01);
            3'd2: e_mode.push_back(2'b11);
            3'd3: e_mode.push_back(2'b00);
            default: e_mode.push_back(2'b10);
          endcase
          if (wd[23:21] == 3'd1 || wd[23:21] == 3'd3) e_addr.push_back({4'b0, wd[13:8]});
          else e_addr.push_back(wd[17:8]);
          e_wdata.push_back(wd[7:0]);
          if (wd[23:21] == 3'd3 || wd[23:21] == 3'd4) nreads++;
          pc = (pc + 1) % 256;
        end
      endcase
    end
    halt_pc = pc;
  endtask

  initial begin
    int n, seen, hpc, nrd, idx;
    logic [2:0] op;
    rst_n = 1'b0; start = 1'b0; spi_ready = 1'b1; intr = 1'b0; rd_ready = 1'b0;
    fill_rom_halt();
    tick; tick;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick;

    // Single short write, with spi_ready low for a while first.
    fill_rom_halt();
    rom[0] = enc(3'd1, 10'h02A, 8'h55);
    spi_ready = 1'b0;
    pulse_start();
    check("wr_busy", 32'(busy), 1);
    repeat (6) tick;
    check("wr_stall_no_req", 32'(q_mode.size()), 0);
    spi_ready = 1'b1;
    wait_halt("wr_halt", 50);
    check("wr_count", 32'(q_mode.size()), 1);
    if (q_mode.size() == 1) begin
      check("wr_mode", 32'(q_mode[0]), 32'h1);
      check("wr_addr", 32'(q_addr[0]), 32'h02A);
      check("wr_wdata", 32'(q_wdata[0]), 32'h55);
    end
    check("wr_busy_end", 32'(busy), 0);
    check("wr_pc", 32'(instr_addr), 1);

    // Five long reads against a 4-deep FIFO with nobody draining it.
    fill_rom_halt();
    for (int k = 0; k < 5; k++) rom[k] = enc(3'd4, 10'h200, 8'($urandom));
    n = 0;
    pulse_start();
    while (q_mode.size() < 4 && n < 100) begin tick; n++; end
    repeat (10) tick;
    check("fifo_stall_count", 32'(q_mode.size()), 4);
    check("fifo_stall_busy", 32'(busy), 1);
    pulse_start();
    repeat (3) tick;
    check("start_ignored", 32'(q_mode.size()), 4);
    pop_check("fifo_pop0");
    n = 0;
    while (q_mode.size() < 5 && n < 20) begin tick; n++; end
    check("fifo_fifth", 32'(q_mode.size()), 5);
    wait_halt("fifo_halt", 50);
    check("fifo_total", 32'(q_mode.size()), 5);
    for (int k = 0; k < q_mode.size(); k++) begin
      check("fifo_mode", 32'(q_mode[k]), 32'h2);
      check("fifo_addr", 32'(q_addr[k]), 32'h200);
      check("fifo_wdata", 32'(q_wdata[k]), 32'(rom[k][7:0]));
    end
    for (int k = 0; k < 4; k++) pop_check("fifo_drain");
    check("fifo_empty", 32'(rd_valid), 0);

    // Randomized programs, optionally skipping one instruction with a JMP.
    for (int it = 0; it < 3; it++) begin
      fill_rom_halt();
      nrd = 0; idx = 0;
      while (idx < 10) begin
        if (idx < 8 && $urandom_range(0, 3) == 0) begin
          rom[idx]     = enc(3'd6, 10'($urandom), 8'(idx + 2));
          rom[idx + 1] = enc(3'd4, 10'($urandom), 8'($urandom));
          idx += 2;
        end else begin
          op = 3'($urandom_range(0, 4));
          if ((op == 3'd3 || op == 3'd4) && nrd == 4) op = 3'd2;
          if (op == 3'd3 || op == 3'd4) nrd++;
          rom[idx] = enc(op, 10'($urandom), 8'($urandom));
          idx++;
        end
      end
      interpret(hpc, nrd);
      pulse_start();
      wait_halt("rnd_halt", 300);
      check("rnd_pc", 32'(instr_addr), 32'(hpc));
      check("rnd_count", 32'(q_mode.size()), 32'(e_mode.size()));
      for (int k = 0; k < e_mode.size() && k < q_mode.size(); k++) begin
        check("rnd_mode", 32'(q_mode[k]), 32'(e_mode[k]));
        check("rnd_addr", 32'(q_addr[k]), 32'(e_addr[k]));
        check("rnd_wdata", 32'(q_wdata[k]), 32'(e_wdata[k]));
      end
      check("rnd_reads", 32'(exp_fifo.size()), 32'(nrd));
      for (int k = 0; k < nrd; k++) pop_check("rnd_rd");
      check("rnd_empty", 32'(rd_valid), 0);
    end

    // WAIT_INTR released by intr ten cycles after start.
    fill_rom_halt();
    rom[0] = enc(3'd5, 10'h000, 8'h00);
    pulse_start();
    repeat (10) tick;
    check("intr_no_early_ack", 32'(intr_ack), 0);
    intr = 1'b1;
    n = 0;
    while (intr_ack !== 1'b1 && n < 5) begin tick; n++; end
    check("intr_ack_latency", 32'(n), 1);
    intr = 1'b0;
    tick;
    check("intr_ack_pulse", 32'(intr_ack), 0);
    wait_halt("intr_halt", 20);
    check("intr_pc", 32'(instr_addr), 1);
    check("intr_no_timeout", 32'(timeout), 0);

    // WAIT_INTR timeout: fetch + decode, then 2^TO_W-1 cycles of waiting.
    pulse_start();
    n = 0;
    while (timeout !== 1'b1 && n < 100) begin tick; n++; end
    check("to_cycles", 32'(n), 32'(2 + (2 ** TO_W - 1)));
    wait_halt("to_halt", 20);
    check("to_pc", 32'(instr_addr), 1);
    check("to_sticky", 32'(timeout), 1);
    pulse_start();
    check("to_cleared", 32'(timeout), 0);
    wait_halt("to_halt2", 50);

    // JMP near the top of the address space, then NOPs wrapping through 0xFF.
    fill_rom_halt();
    rom[0]    = enc(3'd6, 10'h000, 8'hFD);
    rom[8'hFD] = enc(3'd0, 10'h000, 8'h00);
    rom[8'hFE] = enc(3'd0, 10'h000, 8'h00);
    rom[8'hFF] = enc(3'd0, 10'h000, 8'h00);
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      case (k / 2)
        0, 4:  check("wrap_trace", 32'(instr_addr), 32'h00);
        1, 5:  check("wrap_trace", 32'(instr_addr), 32'hFD);
        2:     check("wrap_trace", 32'(instr_addr), 32'hFE);
        default: check("wrap_trace", 32'(instr_addr), 32'hFF);
      endcase
      tick;
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("wrap_reset_busy", 32'(busy), 0);

    // Reset during WAIT_SPI with two reads already buffered.
    fill_rom_halt();
    for (int k = 0; k < 3; k++) rom[k] = enc(3'd3, 10'($urandom), 8'($urandom));
    lat_override = 8;
    pulse_start();
    seen = 0; n = 0;
    while (seen < 3 && n < 200) begin tick; n++; if (spi_req === 1'b1) seen++; end
    tick;
    check("rst_fifo_held", 32'(rd_valid), 1);
    check("rst_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    tick;
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    exp_fifo.delete();
    repeat (12) tick;
    check("late_done_ignored", 32'(rd_valid), 0);
    check("late_done_idle", 32'(busy), 0);
    lat_override = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_seq_engine.md
RF_SEQ_ENGINE -- requirements
Module: rf_seq_engine

Interface
REQ-001 Parameter PC_W, default 8: program-counter and instruction-address width.
REQ-002 Parameter RD_DEPTH, default 4 (power of 2, >=2): read-result FIFO depth.
REQ-003 Parameter TO_W, default 20: WAIT_INTR timeout counter width; timeout = 2^TO_W-1 cycles.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 start  in  1  begin program at address 0; honoured only in IDLE or HALT.
REQ-007 instr_addr  out  PC_W  instruction ROM address.
REQ-008 instr_data  in  24  ROM word; valid one cycle after instr_addr.
REQ-009 spi_req  out  1  one-cycle command pulse to SPI master.
REQ-010 spi_mode  out  2  00 short-read, 01 short-write, 10 long-read, 11 long-write.
REQ-011 spi_addr  out  10 / spi_wdata  out  8  register address / write data, held stable from spi_req until spi_done.
REQ-012 spi_ready  in  1  SPI master idle; spi_done  in  1  one-cycle completion pulse; spi_rdata  in  8  valid with spi_done.
REQ-013 intr  in  1  transceiver interrupt, synchronised upstream, active-high level.
REQ-014 intr_ack  out  1  one-cycle pulse when WAIT_INTR exits on intr.
REQ-015 rd_data  out  8 / rd_valid  out  1 / rd_ready  in  1  read-result FIFO, valid/ready.
REQ-016 busy  out  1 / halted  out  1 / timeout  out  1  status.

Function
REQ-017 Instruction: [23:21] opcode, [20:18] ignored, [17:8] addr, [7:0] data; JMP target = [PC_W-1:0].
REQ-018 Opcodes: 000 NOP, 001 WR_SHORT, 010 WR_LONG, 011 RD_SHORT, 100 RD_LONG, 101 WAIT_INTR, 110 JMP, 111 HALT.
REQ-019 States: IDLE, FETCH, DECODE, ISSUE, WAIT_SPI, WAIT_INT, HALT.
REQ-020 IDLE/HALT + start=1: pc<=0, clear timeout, go FETCH next cycle.
REQ-021 FETCH: instr_addr=pc, go DECODE; DECODE registers instr_data.
REQ-022 DECODE NOP: pc<=pc+1, FETCH. JMP: pc<=target, FETCH. HALT: HALT state, pc unchanged. WAIT_INTR: clear counter, WAIT_INT. SPI ops: ISSUE.
REQ-023 ISSUE: spi_req=1 for exactly one cycle when spi_ready=1 and (write op, or FIFO count < RD_DEPTH); otherwise stall in ISSUE; then WAIT_SPI.
REQ-024 spi_addr: short ops drive {4'b0, addr[5:0]}; long ops drive addr[9:0]; spi_wdata = data.
REQ-025 WAIT_SPI: on spi_done, reads push spi_rdata into FIFO; pc<=pc+1; FETCH next cycle.
REQ-026 Instruction-to-instruction minimum: NOP/JMP 2 cycles; SPI op 3 cycles + downstream latency.
REQ-027 WAIT_INT: intr=1 -> intr_ack pulse, pc<=pc+1, FETCH; counter reaching 2^TO_W-1 -> timeout<=1 (sticky until start or reset), pc<=pc+1, FETCH; intr wins if both in same cycle.
REQ-028 pc increment wraps 2^PC_W-1 -> 0.
REQ-029 FIFO: rd_valid = not empty; rd_data = head; pop on rd_valid&&rd_ready; simultaneous push/pop keeps count; never overflows (REQ-023 stall).
REQ-030 FIFO contents persist across start; cleared only by reset.
REQ-031 busy = 1 in all states except IDLE and HALT; halted = 1 only in HALT.
REQ-032 start while busy ignored; spi_done outside WAIT_SPI ignored.

Reset
REQ-033 rst=0 at any clock edge, including mid-transaction: state IDLE, pc 0, spi_req 0, spi_mode/addr/wdata 0, intr_ack 0, busy 0, halted 0, timeout 0, FIFO empty (rd_valid 0); in-flight spi_done after reset ignored.

Verification
REQ-034 ROM {WR_SHORT a=0x2A d=0x55, HALT}, start -> one spi_req, mode 01, addr 0x02A, wdata 0x55; after spi_done halted=1, busy=0.
REQ-035 RD_LONG a=0x200 x5 with rd_ready=0, RD_DEPTH=4 -> four spi_req, fifth stalls in ISSUE; one pop -> fifth issues; data order preserved.
REQ-036 WAIT_INTR, intr asserted 10 cycles later -> intr_ack pulse, pc advances; intr never, TO_W=4 -> timeout=1 after 15 cycles, pc advances.
REQ-037 JMP to 0x00 at address 0xFF with PC_W=8, plus NOP at 0xFF wrap -> instr_addr sequence 0xFE,0xFF,0x00.
REQ-038 rst=0 during WAIT_SPI with FIFO holding 2 entries -> all outputs at reset values next cycle; later spi_done pushes nothing.
